// File: rtl/perform_qround.sv
// ChaCha20 block core: one time-shared ARX datapath steps through 80 quarter
// rounds (nine cycles each), then adds the saved input back to form the keystream block.
module perform_qround (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  setRounds,
  input  logic [3:0][3:0][31:0] chachamatrixIN,
  output logic [3:0][3:0][31:0] chachamatrixOUT,
  output logic                  blockready,
  output logic [3:0]            blocksproduced
);

  typedef logic [31:0]           word_t;
  typedef logic [3:0][3:0][31:0] matrix_t;
  typedef enum logic [3:0] {IDLE, S0, S1, S2, S3, S4, S5, S6, S7} step_t;
  typedef enum logic [2:0] {Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7} quarter_t;

  word_t    a, b, c, d;
  step_t    Currstep;
  quarter_t CurrQ;
  matrix_t  TEMPpchachastate;
  matrix_t  TEMPchachastateQ4Q7;
  matrix_t  saved;
  logic [3:0] dround;
  logic       armed;

  logic [2:0] qidx;
  logic [1:0] col [4];
  matrix_t    src;
  matrix_t    wb;
  matrix_t    sum;
  word_t      b_fin;

  function automatic word_t rol(input word_t x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Row k of every quarter round is fixed; only the column changes.
  // Diagonal rounds shift the column by the row index.
  always_comb begin
    qidx = CurrQ;
    for (int k = 0; k < 4; k++) begin
      col[k] = qidx[2] ? (qidx[1:0] + 2'(k)) : qidx[1:0];
    end
  end

  assign src   = qidx[2] ? TEMPchachastateQ4Q7 : TEMPpchachastate;
  assign b_fin = rol(b ^ c, 7);

  always_comb begin
    wb = src;
    wb[0][col[0]] = a;
    wb[1][col[1]] = b_fin;
    wb[2][col[2]] = c;
    wb[3][col[3]] = d;
  end

  always_comb begin
    sum = '0;
    for (int r = 0; r < 4; r++) begin
      for (int cc = 0; cc < 4; cc++) begin
        sum[r][cc] = wb[r][cc] + saved[r][cc];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a                   <= '0;
      b                   <= '0;
      c                   <= '0;
      d                   <= '0;
      Currstep            <= IDLE;
      CurrQ               <= Q0;
      TEMPpchachastate    <= '0;
      TEMPchachastateQ4Q7 <= '0;
      saved               <= '0;
      dround              <= '0;
      armed               <= 1'b0;
      chachamatrixOUT     <= '0;
      blockready          <= 1'b0;
      blocksproduced      <= '0;
    end else begin
      blockready <= 1'b0;
      if (setRounds) begin
        // Load also aborts any run in flight.
        TEMPpchachastate    <= chachamatrixIN;
        TEMPchachastateQ4Q7 <= chachamatrixIN;
        saved               <= chachamatrixIN;
        dround              <= '0;
        CurrQ               <= Q0;
        Currstep            <= IDLE;
        armed               <= 1'b1;
      end else if (armed) begin
        case (Currstep)
          IDLE: begin
            a        <= src[0][col[0]];
            b        <= src[1][col[1]];
            c        <= src[2][col[2]];
            d        <= src[3][col[3]];
            Currstep <= S0;
          end
          S0: begin a <= a + b;           Currstep <= S1; end
          S1: begin d <= rol(d ^ a, 16);  Currstep <= S2; end
          S2: begin c <= c + d;           Currstep <= S3; end
          S3: begin b <= rol(b ^ c, 12);  Currstep <= S4; end
          S4: begin a <= a + b;           Currstep <= S5; end
          S5: begin d <= rol(d ^ a, 8);   Currstep <= S6; end
          S6: begin c <= c + d;           Currstep <= S7; end
          S7: begin
            b        <= b_fin;
            Currstep <= IDLE;
            // Column results feed the diagonal matrix after Q3; diagonal
            // results feed the column matrix after Q7.
            if (!qidx[2]) begin
              TEMPpchachastate <= wb;
              if (CurrQ == Q3) TEMPchachastateQ4Q7 <= wb;
            end else begin
              TEMPchachastateQ4Q7 <= wb;
              if (CurrQ == Q7) TEMPpchachastate <= wb;
            end
            if (CurrQ == Q7) begin
              CurrQ <= Q0;
              if (dround == 4'd9) begin
                chachamatrixOUT <= sum;
                blockready      <= 1'b1;
                blocksproduced  <= blocksproduced + 4'd1;
                dround          <= '0;
                armed           <= 1'b0;
              end else begin
                dround <= dround + 4'd1;
              end
            end else begin
              CurrQ <= quarter_t'(qidx + 3'd1);
            end
          end
          default: Currstep <= IDLE;
        endcase
      end else begin
        Currstep <= IDLE;
        CurrQ    <= Q0;
      end
    end
  end

endmodule

// File: tb/tb_perform_qround.sv
// Directed bench for perform_qround: reset, single quarter-round steps,
// RFC 8439 block, abort, counter wrap and hold behaviour.
module tb_perform_qround;

  typedef logic [3:0][3:0][31:0] matrix_t;

  typedef struct {
    int          edge_n;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ec;
    logic [31:0] ed;
  } qr_vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       setRounds;
  matrix_t    min;
  matrix_t    mout;
  logic       blockready;
  logic [3:0] blocksproduced;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  perform_qround dut (
    .clk            (clk),
    .rst            (rst),
    .setRounds      (setRounds),
    .chachamatrixIN (min),
    .chachamatrixOUT(mout),
    .blockready     (blockready),
    .blocksproduced (blocksproduced)
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input matrix_t m);
    setRounds = 1'b1;
    min       = m;
    tick();
    setRounds = 1'b0;
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] qr4(input logic [127:0] v);
    logic [31:0] qa, qb, qc, qd;
    {qa, qb, qc, qd} = v;
    qa += qb; qd ^= qa; qd = rl(qd, 16);
    qc += qd; qb ^= qc; qb = rl(qb, 12);
    qa += qb; qd ^= qa; qd = rl(qd, 8);
    qc += qd; qb ^= qc; qb = rl(qb, 7);
    return {qa, qb, qc, qd};
  endfunction

  function automatic matrix_t chacha_ref(input matrix_t in);
    logic [31:0]  x [16];
    logic [127:0] t;
    int           idx [4];
    matrix_t      res;
    for (int i = 0; i < 16; i++) x[i] = in[i / 4][i % 4];
    for (int r = 0; r < 10; r++) begin
      for (int pass = 0; pass < 2; pass++) begin
        for (int k = 0; k < 4; k++) begin
          for (int w = 0; w < 4; w++) idx[w] = 4 * w + ((pass == 1) ? ((k + w) % 4) : k);
          t = qr4({x[idx[0]], x[idx[1]], x[idx[2]], x[idx[3]]});
          {x[idx[0]], x[idx[1]], x[idx[2]], x[idx[3]]} = t;
        end
      end
    end
    for (int i = 0; i < 16; i++) res[i / 4][i % 4] = x[i] + in[i / 4][i % 4];
    return res;
  endfunction

  function automatic matrix_t rand_matrix();
    matrix_t m;
    for (int i = 0; i < 16; i++) m[i / 4][i % 4] = $urandom;
    return m;
  endfunction

  logic [31:0] rfc_in [16] = '{
    32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
    32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
    32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
    32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
  logic [31:0] rfc_out [16] = '{
    32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
    32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
    32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
    32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

  qr_vec_t qv [9];

  initial begin
    matrix_t m, m2, exp_m, hold_out;
    int      pulses, pulse_edge;

    qv[0] = '{1, 32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567};
    qv[1] = '{2, 32'h12131415, 32'h01020304, 32'h9b8d6f43, 32'h01234567};
    qv[2] = '{3, 32'h12131415, 32'h01020304, 32'h9b8d6f43, 32'h51721330};
    qv[3] = '{4, 32'h12131415, 32'h01020304, 32'hecff8273, 32'h51721330};
    qv[4] = '{5, 32'h12131415, 32'hd8177edf, 32'hecff8273, 32'h51721330};
    qv[5] = '{6, 32'hea2a92f4, 32'hd8177edf, 32'hecff8273, 32'h51721330};
    qv[6] = '{7, 32'hea2a92f4, 32'hd8177edf, 32'hecff8273, 32'h5881c4bb};
    qv[7] = '{8, 32'hea2a92f4, 32'hd8177edf, 32'h4581472e, 32'h5881c4bb};
    qv[8] = '{9, 32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb};

    rst = 1'b1; setRounds = 1'b0; min = '0;
    tick(); tick();
    chk("reset_out", mout, '0);
    chk("reset_blockready", blockready, 0);
    chk("reset_blocksproduced", blocksproduced, 0);
    chk("reset_currstep", int'(dut.Currstep), 0);
    chk("reset_currq", int'(dut.CurrQ), 0);
    chk("reset_abcd", {dut.a, dut.b, dut.c, dut.d}, '0);
    rst = 1'b0;
    tick();
    chk("idle_disarmed_step", int'(dut.Currstep), 0);

    // Single quarter round on column 0, checked step by step
    m = '0;
    m[0][0] = 32'h11111111; m[1][0] = 32'h01020304;
    m[2][0] = 32'h9b8d6f43; m[3][0] = 32'h01234567;
    load(m);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("qr_abcd_edge%0d", qv[i].edge_n), {dut.a, dut.b, dut.c, dut.d},
          {qv[i].ea, qv[i].eb, qv[i].ec, qv[i].ed});
    end
    exp_m = '0;
    exp_m[0][0] = 32'hea2a92f4; exp_m[1][0] = 32'hcb1cf8ce;
    exp_m[2][0] = 32'h4581472e; exp_m[3][0] = 32'h5881c4bb;
    chk("qr_state_edge9", dut.TEMPpchachastate, exp_m);

    // RFC 8439 block
    for (int i = 0; i < 16; i++) begin
      m[i / 4][i % 4]     = rfc_in[i];
      exp_m[i / 4][i % 4] = rfc_out[i];
    end
    chk("model_vs_rfc", chacha_ref(m), exp_m);
    load(m);
    pulses = 0;
    for (int e = 1; e <= 721; e++) begin
      tick();
      if (e < 720 && blockready) pulses++;
      if (e == 720) begin
        chk("rfc_blockready_720", blockready, 1);
        chk("rfc_out", mout, exp_m);
        chk("rfc_blocksproduced", blocksproduced, 1);
      end
      if (e == 721) begin
        chk("rfc_blockready_721", blockready, 0);
        chk("rfc_idle_after", int'(dut.Currstep), 0);
      end
    end
    chk("rfc_early_pulses", pulses, 0);

    // Abort at edge 300 with a new matrix; input changes mid-run are ignored
    m  = rand_matrix();
    m2 = rand_matrix();
    load(m);
    pulses = 0;
    for (int e = 1; e < 300; e++) begin
      tick();
      if (blockready) pulses++;
    end
    load(m2);
    min = rand_matrix();
    pulse_edge = -1;
    for (int e = 1; e <= 721; e++) begin
      tick();
      if (e == 400) min = rand_matrix();
      if (blockready) begin pulses++; pulse_edge = e; end
    end
    chk("abort_pulses", pulses, 1);
    chk("abort_pulse_edge", pulse_edge, 720);
    chk("abort_out", mout, chacha_ref(m2));
    chk("abort_blocksproduced", blocksproduced, 2);

    // Counter wrap over 16 back-to-back blocks
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("wrap_reset_count", blocksproduced, 0);
    for (int k = 0; k < 16; k++) begin
      m = rand_matrix();
      load(m);
      pulses = 0; pulse_edge = -1;
      for (int e = 1; e <= 721; e++) begin
        tick();
        if (blockready) begin pulses++; pulse_edge = e; end
      end
      chk($sformatf("wrap_pulses_%0d", k), pulses, 1);
      chk($sformatf("wrap_edge_%0d", k), pulse_edge, 720);
      chk($sformatf("wrap_count_%0d", k), blocksproduced, (k + 1) % 16);
      chk($sformatf("wrap_out_%0d", k), mout, chacha_ref(m));
    end
    hold_out = chacha_ref(m);

    // Hold: no load for 1000 cycles
    pulses = 0;
    for (int e = 0; e < 1000; e++) begin
      if (e % 100 == 0) min = rand_matrix();
      tick();
      if (blockready) pulses++;
    end
    chk("hold_pulses", pulses, 0);
    chk("hold_out", mout, hold_out);
    chk("hold_blocksproduced", blocksproduced, 0);
    chk("hold_currstep", int'(dut.Currstep), 0);
    chk("hold_currq", int'(dut.CurrQ), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
